// File: rtl/seq_multiplier_if.sv
// Start/done handshake bundle for seq_multiplier: operands and mode in, status and product out.
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add WIDTH x WIDTH multiplier, one partial product per clock, with
// sign handled by multiplying magnitudes and negating the final sum.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [PW-1:0]    acc_q,     acc_d;
  logic             neg_q,     neg_d;
  logic [PW-1:0]    product_q, product_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic [PW-1:0]    addend_s;
  logic [PW-1:0]    acc_sum_s;

  // The most negative operand maps to 2**(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sm);
    return (sm && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Next-state, datapath and output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    addend_s  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : {PW{1'b0}};
    acc_sum_s = acc_q + addend_s;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          mcand_d  = magnitude(bus.a, bus.signed_mode);
          mplier_d = magnitude(bus.b, bus.signed_mode);
          neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = {PW{1'b0}};
          cnt_d    = {CW{1'b0}};
          busy_d   = 1'b1;
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        acc_d    = acc_sum_s;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = neg_q ? (~acc_sum_s + PW'(1)) : acc_sum_s;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_DONE;
        end else begin
          busy_d    = 1'b1;
          state_d   = ST_CALC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {PW{1'b0}};
      neg_q     <= 1'b0;
      product_q <= {PW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and exhaustive checks of seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(4)) bus4 ();
  seq_multiplier_if #(.WIDTH(8)) bus8 ();

  seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_mul4(input logic sm, input logic [3:0] ai, input logic [3:0] bi);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    sa = {{4{ai[3]}}, ai};
    sb = {{4{bi[3]}}, bi};
    if (sm) return 8'(sa * sb);
    else    return 8'({4'b0000, ai} * {4'b0000, bi});
  endfunction

  task automatic op4(input logic sm, input logic [3:0] ai, input logic [3:0] bi,
                     input logic [7:0] exp, input string tag);
    int cyc = 0;
    int busy_cnt = 0;
    bus4.signed_mode = sm; bus4.a = ai; bus4.b = bi; bus4.start = 1'b1;
    step;
    bus4.start = 1'b0;
    while (bus4.done !== 1'b1 && cyc < 20) begin
      if (bus4.busy === 1'b1) busy_cnt++;
      step;
      cyc++;
    end
    vectors++;
    if (cyc !== 4) begin
      miscompares++; $display("FAIL %s latency: got %0d cycles, want 4", tag, cyc);
    end
    vectors++;
    if (busy_cnt !== 4) begin
      miscompares++; $display("FAIL %s busy_cycles: got %0d, want 4", tag, busy_cnt);
    end
    vectors++;
    if (bus4.product !== exp || bus4.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s product: got %h busy=%b, want %h busy=0", tag, bus4.product, bus4.busy, exp);
    end
    step;
    vectors++;
    if (bus4.done !== 1'b0 || bus4.product !== exp) begin
      miscompares++;
      $display("FAIL %s hold: got done=%b product=%h, want done=0 product=%h", tag, bus4.done, bus4.product, exp);
    end
  endtask

  task automatic op8(input logic sm, input logic [7:0] ai, input logic [7:0] bi,
                     input logic [15:0] exp, input string tag);
    int cyc = 0;
    bus8.signed_mode = sm; bus8.a = ai; bus8.b = bi; bus8.start = 1'b1;
    step;
    bus8.start = 1'b0;
    while (bus8.done !== 1'b1 && cyc < 40) begin
      step;
      cyc++;
    end
    vectors++;
    if (cyc !== 8) begin
      miscompares++; $display("FAIL %s latency: got %0d cycles, want 8", tag, cyc);
    end
    vectors++;
    if (bus8.product !== exp) begin
      miscompares++; $display("FAIL %s product: got %h, want %h", tag, bus8.product, exp);
    end
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    repeat (2) step;
    vectors++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.product !== 8'h00) begin
      miscompares++;
      $display("FAIL reset4: got busy=%b done=%b product=%h, want 0 0 00", bus4.busy, bus4.done, bus4.product);
    end
    vectors++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.product !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset8: got busy=%b done=%b product=%h, want 0 0 0000", bus8.busy, bus8.done, bus8.product);
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_unsigned;
    op4(1'b0, 4'd15, 4'd15, 8'hE1, "u_15x15");
    op4(1'b0, 4'd0,  4'd9,  8'h00, "u_0x9");
    op4(1'b0, 4'd1,  4'd15, 8'h0F, "u_1x15");
    op4(1'b0, 4'd8,  4'd3,  8'h18, "u_8x3");
  endtask

  task automatic test_signed;
    op4(1'b1, 4'b1000, 4'b0011, 8'hE8, "s_m8x3");
    op4(1'b1, 4'b1000, 4'b1000, 8'h40, "s_m8xm8");
    op4(1'b1, 4'hF,    4'h1,    8'hFF, "s_m1x1");
    op4(1'b1, 4'h7,    4'hA,    8'hD6, "s_7xm6");
  endtask

  task automatic test_exhaustive_back_to_back;
    logic [8:0] v;
    logic [7:0] exp;
    v = 9'd0;
    bus4.signed_mode = v[8]; bus4.a = v[3:0]; bus4.b = v[7:4]; bus4.start = 1'b1;
    step;
    bus4.start = 1'b0;
    for (int idx = 0; idx < 512; idx++) begin
      v = 9'(idx);
      exp = ref_mul4(v[8], v[3:0], v[7:4]);
      repeat (4) step;
      vectors++;
      if (bus4.done !== 1'b1 || bus4.product !== exp) begin
        miscompares++;
        $display("FAIL exh sm=%b a=%h b=%h: got done=%b product=%h, want done=1 product=%h",
                 v[8], v[3:0], v[7:4], bus4.done, bus4.product, exp);
      end
      if (idx < 511) begin
        v = 9'(idx + 1);
        bus4.signed_mode = v[8]; bus4.a = v[3:0]; bus4.b = v[7:4]; bus4.start = 1'b1;
        step;
        bus4.start = 1'b0;
        vectors++;
        if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_accept idx=%0d: got busy=%b done=%b, want busy=1 done=0", idx + 1, bus4.busy, bus4.done);
        end
      end
    end
    step;
  endtask

  task automatic test_start_during_calc;
    int done_cnt = 0;
    logic [7:0] prod_at_done = 8'hxx;
    bus4.signed_mode = 1'b0; bus4.a = 4'd3; bus4.b = 4'd5; bus4.start = 1'b1;
    step;
    bus4.signed_mode = 1'b1; bus4.a = 4'd9; bus4.b = 4'd9;
    repeat (2) step;
    bus4.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (bus4.done === 1'b1) begin
        done_cnt++;
        prod_at_done = bus4.product;
      end
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL calc_start done_pulses: got %0d, want 1", done_cnt);
    end
    vectors++;
    if (prod_at_done !== 8'h0F || bus4.product !== 8'h0F) begin
      miscompares++;
      $display("FAIL calc_start product: got %h (final %h), want 0f", prod_at_done, bus4.product);
    end
  endtask

  task automatic test_reset_mid_calc;
    int done_cnt = 0;
    bus4.signed_mode = 1'b0; bus4.a = 4'd7; bus4.b = 4'd9; bus4.start = 1'b1;
    step;
    bus4.start = 1'b0;
    step;
    rst = 1'b1;
    step;
    vectors++;
    if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus4.product !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b done=%b product=%h, want 0 0 00", bus4.busy, bus4.done, bus4.product);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) done_cnt++;
    end
    vectors++;
    if (done_cnt !== 0 || bus4.product !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_after: got activity=%0d product=%h, want 0 00", done_cnt, bus4.product);
    end
    op4(1'b0, 4'd7, 4'd9, 8'h3F, "u_7x9_after_reset");
  endtask

  task automatic test_width8;
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8_u_255x255");
    op8(1'b1, 8'h80, 8'h7F, 16'hC080, "w8_s_m128x127");
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "w8_s_m128xm128");
    op8(1'b0, 8'h00, 8'hAB, 16'h0000, "w8_u_0xab");
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_exhaustive_back_to_back;
    test_start_during_calc;
    test_reset_mid_calc;
    test_width8;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
